// File: rtl/mandel_fb_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : mandel_fb_writer_if
// Purpose  : Pixel-side and framebuffer-write-side signals of mandel_fb_writer.
// Revision : 1.0
// ============================================================================

interface mandel_fb_writer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_level_w = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]           pixel_data_in;
    logic                 pixel_frame_start_in;
    logic                 pixel_valid_in;
    logic                 pixel_ready_out;
    logic [3:0]           write_data_out;
    logic                 write_toggle_out;
    logic                 reset_write_ptr_out;
    logic                 wrote_data_in;
    logic [c_level_w-1:0] fifo_level_out;
    logic                 busy_out;

    // master is the writer itself; slave is the engine / RP2040 side
    modport master (
        input  pixel_data_in,
        input  pixel_frame_start_in,
        input  pixel_valid_in,
        input  wrote_data_in,
        output pixel_ready_out,
        output write_data_out,
        output write_toggle_out,
        output reset_write_ptr_out,
        output fifo_level_out,
        output busy_out
    );

    modport slave (
        output pixel_data_in,
        output pixel_frame_start_in,
        output pixel_valid_in,
        output wrote_data_in,
        input  pixel_ready_out,
        input  write_data_out,
        input  write_toggle_out,
        input  reset_write_ptr_out,
        input  fifo_level_out,
        input  busy_out
    );
endinterface

`default_nettype wire

// File: rtl/mandel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : mandel_fb_writer
// Purpose  : FIFO-buffered 4-bit pixel writer driving the toggle/echo
//            framebuffer write handshake. Optional per-frame automatic pointer
//            reset enabled by MANDEL_FB_WRITER_AUTO_PTR_RESET_EN.
// Revision : 1.0
// ============================================================================

module mandel_fb_writer #(
    parameter int FIFO_DEPTH       = 4,
    parameter int HOLD_CYCLES      = 4,
    parameter int PTR_RESET_CYCLES = 8,
    parameter int FRAME_PIXELS     = 153600
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mandel_fb_writer_if.master bus
);

    localparam int c_addr_w  = $clog2(FIFO_DEPTH);
    localparam int c_level_w = c_addr_w + 1;
    localparam int c_hold_w  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_prst_w  = (PTR_RESET_CYCLES > 1) ? $clog2(PTR_RESET_CYCLES) : 1;

    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_prst_w-1:0] c_prst_load = c_prst_w'(PTR_RESET_CYCLES - 1);

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two and at least 2");
        end
        if (HOLD_CYCLES < 1 || PTR_RESET_CYCLES < 1) begin : g_bad_cycles
            $error("HOLD_CYCLES and PTR_RESET_CYCLES must be at least 1");
        end
        if (FRAME_PIXELS < 2) begin : g_bad_frame
            $error("FRAME_PIXELS must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PTR_RST   = 3'd1,
        S_TOGGLE    = 3'd2,
        S_WAIT_ECHO = 3'd3,
        S_HOLD      = 3'd4
    } state_t;

    // ---------------- pixel FIFO ----------------
    logic [4:0]           r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0]  r_wr_ptr;
    logic [c_addr_w-1:0]  r_rd_ptr;
    logic [c_level_w-1:0] r_level;
    logic [c_level_w-1:0] w_level_nxt;
    logic                 r_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic [4:0]           w_head;

    // ---------------- write FSM ----------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_data;
    logic [3:0]           w_data_nxt;
    logic                 r_toggle;
    logic                 w_toggle_nxt;
    logic                 r_ptr_rst;
    logic                 w_ptr_rst_nxt;
    logic [c_hold_w-1:0]  r_hold_cnt;
    logic [c_hold_w-1:0]  w_hold_cnt_nxt;
    logic [c_prst_w-1:0]  r_prst_cnt;
    logic [c_prst_w-1:0]  w_prst_cnt_nxt;
    logic                 w_need_ptr_rst;

    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rd_ptr];
    // Ready is a register, so a pop in a full cycle never admits a push.
    assign w_push  = bus.pixel_valid_in && r_ready;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_level_w'(1);
            2'b01:   w_level_nxt = r_level - c_level_w'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
            end
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != c_level_w'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.pixel_frame_start_in, bus.pixel_data_in};
        end
    end

`ifdef MANDEL_FB_WRITER_AUTO_PTR_RESET_EN
    localparam int c_pix_w = $clog2(FRAME_PIXELS);

    logic [c_pix_w-1:0] r_pix_cnt;
    logic [c_pix_w-1:0] w_pix_cnt_nxt;
    logic               r_force_ptr;
    logic               w_force_ptr_nxt;
    logic               w_hold_exit;

    assign w_hold_exit    = (r_state == S_HOLD) && (r_hold_cnt == '0);
    assign w_need_ptr_rst = w_head[4] || r_force_ptr;

    // A popped frame start and a pending forced reset collapse into one PTR_RST.
    always_comb begin
        w_pix_cnt_nxt   = r_pix_cnt;
        w_force_ptr_nxt = r_force_ptr;
        if (w_pop) begin
            w_force_ptr_nxt = 1'b0;
            if (w_head[4]) begin
                w_pix_cnt_nxt = '0;
            end
        end
        if (w_hold_exit) begin
            if (r_pix_cnt == c_pix_w'(FRAME_PIXELS - 1)) begin
                w_pix_cnt_nxt   = '0;
                w_force_ptr_nxt = 1'b1;
            end else begin
                w_pix_cnt_nxt = r_pix_cnt + c_pix_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_cnt   <= '0;
            r_force_ptr <= 1'b0;
        end else begin
            r_pix_cnt   <= w_pix_cnt_nxt;
            r_force_ptr <= w_force_ptr_nxt;
        end
    end
`else
    assign w_need_ptr_rst = w_head[4];
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_toggle_nxt   = r_toggle;
        w_ptr_rst_nxt  = r_ptr_rst;
        w_hold_cnt_nxt = r_hold_cnt;
        w_prst_cnt_nxt = r_prst_cnt;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_data_nxt = w_head[3:0];
                    if (w_need_ptr_rst) begin
                        w_ptr_rst_nxt  = 1'b1;
                        w_prst_cnt_nxt = c_prst_load;
                        w_state_nxt    = S_PTR_RST;
                    end else begin
                        w_state_nxt = S_TOGGLE;
                    end
                end
            end
            S_PTR_RST: begin
                if (r_prst_cnt == '0) begin
                    w_ptr_rst_nxt = 1'b0;
                    w_state_nxt   = S_TOGGLE;
                end else begin
                    w_prst_cnt_nxt = r_prst_cnt - c_prst_w'(1);
                end
            end
            S_TOGGLE: begin
                w_toggle_nxt = ~r_toggle;
                w_state_nxt  = S_WAIT_ECHO;
            end
            S_WAIT_ECHO: begin
                // No timeout: the RP2040 side may stall arbitrarily long.
                if (bus.wrote_data_in == r_toggle) begin
                    w_hold_cnt_nxt = c_hold_load;
                    w_state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - c_hold_w'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_data     <= 4'h0;
            r_toggle   <= 1'b0;
            r_ptr_rst  <= 1'b0;
            r_hold_cnt <= '0;
            r_prst_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_data     <= w_data_nxt;
            r_toggle   <= w_toggle_nxt;
            r_ptr_rst  <= w_ptr_rst_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_prst_cnt <= w_prst_cnt_nxt;
        end
    end

    assign bus.pixel_ready_out     = r_ready;
    assign bus.write_data_out      = r_data;
    assign bus.write_toggle_out    = r_toggle;
    assign bus.reset_write_ptr_out = r_ptr_rst;
    assign bus.fifo_level_out      = r_level;
    assign bus.busy_out            = (r_state != S_IDLE) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_mandel_fb_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mandel_fb_writer
// Purpose  : Directed self-checking bench for mandel_fb_writer.
// Revision : 1.0
// ============================================================================

module tb_mandel_fb_writer;

    localparam int FIFO_DEPTH       = 4;
    localparam int HOLD_CYCLES      = 4;
    localparam int PTR_RESET_CYCLES = 8;
    localparam int FRAME_PIXELS     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic echo_en = 1'b1;
    logic echo_q;

    int checks = 0;
    int failures = 0;
    logic exp_tog = 1'b0;

    mandel_fb_writer_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    mandel_fb_writer #(
        .FIFO_DEPTH      (FIFO_DEPTH),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .PTR_RESET_CYCLES(PTR_RESET_CYCLES),
        .FRAME_PIXELS    (FRAME_PIXELS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // RP2040-side registered echo of the toggle; echo_en=0 models a stalled echo
    always @(posedge clk) begin
        if (rst)          echo_q <= 1'b0;
        else if (echo_en) echo_q <= bus.write_toggle_out;
    end
    assign bus.wrote_data_in = echo_q;

    // Observation log: toggles seen, nibble at each toggle, pointer-reset activity
    int         tog_cnt = 0;
    int         ptr_hi_cnt = 0;
    int         ptr_rise_tog = -1;
    logic [3:0] nib_q[$];
    logic       prev_tog = 1'b0;
    logic       prev_ptr = 1'b0;
    logic       rst_d = 1'b1;

    always @(negedge clk) begin
        if (!rst && !rst_d) begin
            if (bus.write_toggle_out !== prev_tog) begin
                nib_q.push_back(bus.write_data_out);
                tog_cnt++;
            end
            if (bus.reset_write_ptr_out === 1'b1) begin
                ptr_hi_cnt++;
                if (!prev_ptr) ptr_rise_tog = tog_cnt;
            end
        end
        prev_tog = bus.write_toggle_out;
        prev_ptr = bus.reset_write_ptr_out;
        rst_d    = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_out !== 1'b0 && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic push_seq(input logic [3:0] first, input int count);
        int sent = 0;
        int n = 0;
        logic rdy;
        bus.pixel_frame_start_in = 1'b0;
        while (sent < count && n < 400) begin
            bus.pixel_data_in  = first + 4'(sent);
            bus.pixel_valid_in = 1'b1;
            rdy = bus.pixel_ready_out;
            step();
            n++;
            if (rdy) sent++;
        end
        bus.pixel_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pixel_valid_in = 1'b0;
        bus.pixel_data_in = 4'h0;
        bus.pixel_frame_start_in = 1'b0;
        echo_en = 1'b1;
        step();
        step();
        checks++; if (bus.write_data_out !== 4'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.write_data_out); end
        checks++; if (bus.write_toggle_out !== 1'b0) begin failures++; $display("FAIL reset_toggle got=%b exp=0", bus.write_toggle_out); end
        checks++; if (bus.reset_write_ptr_out !== 1'b0) begin failures++; $display("FAIL reset_ptr got=%b exp=0", bus.reset_write_ptr_out); end
        checks++; if (bus.pixel_ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.pixel_ready_out); end
        checks++; if (bus.fifo_level_out !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.fifo_level_out); end
        checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_out); end
        rst = 1'b0;
        step();
        checks++; if (bus.pixel_ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready_rise got=%b exp=1", bus.pixel_ready_out); end
        exp_tog = 1'b0;
    endtask

    task automatic test_single_pixel();
        bus.pixel_data_in = 4'hA;
        bus.pixel_frame_start_in = 1'b0;
        bus.pixel_valid_in = 1'b1;
        step();
        bus.pixel_valid_in = 1'b0;
        checks++; if (bus.fifo_level_out !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", bus.fifo_level_out); end
        step();
        checks++; if (bus.write_data_out !== 4'hA) begin failures++; $display("FAIL single_data got=%0h exp=a", bus.write_data_out); end
        checks++; if (bus.write_toggle_out !== exp_tog) begin failures++; $display("FAIL single_tog_before got=%b exp=%b", bus.write_toggle_out, exp_tog); end
        step();
        exp_tog = ~exp_tog;
        checks++; if (bus.write_toggle_out !== exp_tog) begin failures++; $display("FAIL single_tog_flip got=%b exp=%b", bus.write_toggle_out, exp_tog); end
        repeat (5) step();
        checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL single_busy_hold got=%b exp=1", bus.busy_out); end
        step();
        checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", bus.busy_out); end
    endtask

    task automatic test_frame_start();
        int hi = 0;
        int bad = 0;
        bus.pixel_data_in = 4'h3;
        bus.pixel_frame_start_in = 1'b1;
        bus.pixel_valid_in = 1'b1;
        step();
        bus.pixel_valid_in = 1'b0;
        bus.pixel_frame_start_in = 1'b0;
        step();
        checks++; if (bus.write_data_out !== 4'h3) begin failures++; $display("FAIL fs_data got=%0h exp=3", bus.write_data_out); end
        repeat (8) begin
            if (bus.reset_write_ptr_out === 1'b1) hi++;
            if (bus.write_data_out !== 4'h3 || bus.write_toggle_out !== exp_tog) bad++;
            step();
        end
        checks++; if (hi != 8) begin failures++; $display("FAIL fs_ptr_cycles got=%0d exp=8", hi); end
        checks++; if (bad != 0) begin failures++; $display("FAIL fs_stable got=%0d unstable cycles exp=0", bad); end
        checks++; if (bus.reset_write_ptr_out !== 1'b0) begin failures++; $display("FAIL fs_ptr_fall got=%b exp=0", bus.reset_write_ptr_out); end
        checks++; if (bus.write_toggle_out !== exp_tog) begin failures++; $display("FAIL fs_tog_early got=%b exp=%b", bus.write_toggle_out, exp_tog); end
        step();
        exp_tog = ~exp_tog;
        checks++; if (bus.write_toggle_out !== exp_tog) begin failures++; $display("FAIL fs_tog_flip got=%b exp=%b", bus.write_toggle_out, exp_tog); end
        checks++; if (bus.write_data_out !== 4'h3) begin failures++; $display("FAIL fs_data_tog got=%0h exp=3", bus.write_data_out); end
        wait_idle();
        checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL fs_idle_timeout busy=%b exp=0", bus.busy_out); end
    endtask

    task automatic test_back_to_back();
        int base_tog = tog_cnt;
        int base_ptr = ptr_hi_cnt;
        int base_q = nib_q.size();
        int bad = 0;
        logic rdy;
        int n = 0;
        echo_en = 1'b0;
        push_seq(4'h1, 5);
        checks++; if (bus.fifo_level_out !== 3'd4) begin failures++; $display("FAIL b2b_level_full got=%0d exp=4", bus.fifo_level_out); end
        checks++; if (bus.pixel_ready_out !== 1'b0) begin failures++; $display("FAIL b2b_ready_full got=%b exp=0", bus.pixel_ready_out); end
        checks++; if (bus.write_data_out !== 4'h1) begin failures++; $display("FAIL b2b_head_data got=%0h exp=1", bus.write_data_out); end
        checks++; if (tog_cnt - base_tog != 1) begin failures++; $display("FAIL b2b_stall_toggles got=%0d exp=1", tog_cnt - base_tog); end
        bus.pixel_data_in = 4'h6;
        bus.pixel_valid_in = 1'b1;
        repeat (3) step();
        checks++; if (bus.fifo_level_out !== 3'd4) begin failures++; $display("FAIL b2b_no_push_full got=%0d exp=4", bus.fifo_level_out); end
        echo_en = 1'b1;
        rdy = 1'b0;
        while (!rdy && n < 200) begin
            rdy = bus.pixel_ready_out;
            step();
            n++;
        end
        bus.pixel_valid_in = 1'b0;
        wait_idle();
        checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL b2b_idle_timeout busy=%b exp=0", bus.busy_out); end
        checks++; if (tog_cnt - base_tog != 6) begin failures++; $display("FAIL b2b_toggles got=%0d exp=6", tog_cnt - base_tog); end
        if (nib_q.size() < base_q + 6) bad = 99;
        else for (int i = 0; i < 6; i++) if (nib_q[base_q + i] !== 4'(i + 1)) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_order got=%0d wrong nibbles exp=0", bad); end
`ifndef MANDEL_FB_WRITER_AUTO_PTR_RESET_EN
        checks++; if (ptr_hi_cnt - base_ptr != 0) begin failures++; $display("FAIL b2b_no_ptr got=%0d ptr cycles exp=0", ptr_hi_cnt - base_ptr); end
`endif
    endtask

    task automatic test_echo_stall();
        int base_tog = tog_cnt;
        echo_en = 1'b0;
        bus.pixel_data_in = 4'h7;
        bus.pixel_frame_start_in = 1'b0;
        bus.pixel_valid_in = 1'b1;
        step();
        bus.pixel_valid_in = 1'b0;
        step();
        step();
        exp_tog = ~exp_tog;
        repeat (20) step();
        checks++; if (bus.write_data_out !== 4'h7) begin failures++; $display("FAIL stall_data got=%0h exp=7", bus.write_data_out); end
        checks++; if (bus.write_toggle_out !== exp_tog) begin failures++; $display("FAIL stall_tog got=%b exp=%b", bus.write_toggle_out, exp_tog); end
        checks++; if (bus.busy_out !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", bus.busy_out); end
        checks++; if (tog_cnt - base_tog != 1) begin failures++; $display("FAIL stall_toggles got=%0d exp=1", tog_cnt - base_tog); end
        echo_en = 1'b1;
        wait_idle();
        checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL stall_idle_timeout busy=%b exp=0", bus.busy_out); end
        checks++; if (tog_cnt - base_tog != 1) begin failures++; $display("FAIL stall_release_toggles got=%0d exp=1", tog_cnt - base_tog); end
    endtask

    task automatic test_reset_mid();
        int base_tog;
        echo_en = 1'b1;
        bus.pixel_frame_start_in = 1'b0;
        bus.pixel_valid_in = 1'b1;
        bus.pixel_data_in = 4'h9; step();
        bus.pixel_data_in = 4'hB; step();
        bus.pixel_data_in = 4'hC; step();
        bus.pixel_data_in = 4'hD; step();
        bus.pixel_valid_in = 1'b0;
        step();
        checks++; if (bus.fifo_level_out !== 3'd3) begin failures++; $display("FAIL mid_level_before got=%0d exp=3", bus.fifo_level_out); end
        rst = 1'b1;
        step();
        checks++; if (bus.write_data_out !== 4'h0) begin failures++; $display("FAIL mid_data got=%0h exp=0", bus.write_data_out); end
        checks++; if (bus.write_toggle_out !== 1'b0) begin failures++; $display("FAIL mid_toggle got=%b exp=0", bus.write_toggle_out); end
        checks++; if (bus.reset_write_ptr_out !== 1'b0) begin failures++; $display("FAIL mid_ptr got=%b exp=0", bus.reset_write_ptr_out); end
        checks++; if (bus.pixel_ready_out !== 1'b0) begin failures++; $display("FAIL mid_ready got=%b exp=0", bus.pixel_ready_out); end
        checks++; if (bus.fifo_level_out !== 3'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", bus.fifo_level_out); end
        checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", bus.busy_out); end
        rst = 1'b0;
        exp_tog = 1'b0;
        step();
        checks++; if (bus.pixel_ready_out !== 1'b1) begin failures++; $display("FAIL mid_ready_rise got=%b exp=1", bus.pixel_ready_out); end
        base_tog = tog_cnt;
        repeat (10) step();
        checks++; if (tog_cnt - base_tog != 0 || bus.busy_out !== 1'b0) begin failures++; $display("FAIL mid_abandon toggles=%0d busy=%b exp toggles=0 busy=0", tog_cnt - base_tog, bus.busy_out); end
    endtask

`ifdef MANDEL_FB_WRITER_AUTO_PTR_RESET_EN
    task automatic test_auto_ptr();
        int base_tog = tog_cnt;
        int base_ptr = ptr_hi_cnt;
        echo_en = 1'b1;
        push_seq(4'h1, 5);
        wait_idle();
        checks++; if (bus.busy_out !== 1'b0) begin failures++; $display("FAIL auto_idle_timeout busy=%b exp=0", bus.busy_out); end
        checks++; if (tog_cnt - base_tog != 5) begin failures++; $display("FAIL auto_toggles got=%0d exp=5", tog_cnt - base_tog); end
        checks++; if (ptr_hi_cnt - base_ptr != 8) begin failures++; $display("FAIL auto_ptr_cycles got=%0d exp=8", ptr_hi_cnt - base_ptr); end
        checks++; if (ptr_rise_tog != base_tog + 4) begin failures++; $display("FAIL auto_ptr_position got=%0d exp=%0d", ptr_rise_tog - base_tog, 4); end
    endtask
`endif

    initial begin
        bus.pixel_valid_in = 1'b0;
        bus.pixel_data_in = 4'h0;
        bus.pixel_frame_start_in = 1'b0;
        test_reset();
        test_single_pixel();
        test_frame_start();
        test_back_to_back();
        test_echo_stall();
        test_reset_mid();
`ifdef MANDEL_FB_WRITER_AUTO_PTR_RESET_EN
        test_auto_ptr();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mandel_fb_writer.md
Name: mandel_fb_writer

Overview:
- Upstream neighbour of the VGA QSPI framebuffer reader; accepts 4-bit gray pixels from the Mandelbrot iteration engine and hands them to the RP2040 write path.
- Drives the framebuffer write nibble, write toggle and write-pointer reset, and uses the registered echo of the toggle as acknowledge.
- A small FIFO decouples the bursty engine from the slow per-pixel write handshake.

Parameters:
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, at least 2.
- HOLD_CYCLES, 4, cycles data and toggle stay stable after the echo matches; at least 1.
- PTR_RESET_CYCLES, 8, cycles reset_write_ptr_out is held high; at least 1.
- FRAME_PIXELS, 153600, pixels per frame (320x480); used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pixel_data_in  in  4  gray value from the engine
- pixel_frame_start_in  in  1  marks the first pixel of a frame; sideband, qualified by pixel_valid_in
- pixel_valid_in  in  1  engine has a pixel
- pixel_ready_out  out  1  FIFO can accept
- write_data_out  out  4  nibble to the framebuffer write_data_in
- write_toggle_out  out  1  flips once per nibble; goes to write_data
- reset_write_ptr_out  out  1  write-pointer reset to the RP2040
- wrote_data_in  in  1  registered echo of write_toggle_out
- fifo_level_out  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- busy_out  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (rst high at a clk edge): FIFO flushed, FSM to IDLE, HOLD/PTR counters cleared.
  - Outputs after reset: write_data_out=0, write_toggle_out=0, reset_write_ptr_out=0, pixel_ready_out=0, fifo_level_out=0, busy_out=0.
  - pixel_ready_out rises on the first cycle with rst low.
  - Reset mid-operation abandons the transfer in progress; no pending nibble is completed.
- FIFO:
  - Each entry is 5 bits: {frame_start, data}.
  - Push when pixel_valid_in && pixel_ready_out.
  - pixel_ready_out = !full. It is registered-equivalent and does not depend on pop in the same cycle, so when full no push happens even if a pop occurs.
  - Pop occurs only in IDLE when not empty.
  - Pointers wrap modulo FIFO_DEPTH. Order is strictly preserved.
- FSM:
  - IDLE: if not empty, pop the head into write_data_out. If head.frame_start, go to PTR_RST with reset_write_ptr_out<=1; else go to TOGGLE.
  - PTR_RST: hold reset_write_ptr_out high for exactly PTR_RESET_CYCLES cycles, then drive it low and go to TOGGLE.
  - TOGGLE: write_toggle_out <= ~write_toggle_out; go to WAIT_ECHO.
  - WAIT_ECHO: stay until wrote_data_in == write_toggle_out, then load the hold counter and go to HOLD. There is no timeout; the state may wait indefinitely with outputs stable.
  - HOLD: stay exactly HOLD_CYCLES cycles, then go to IDLE.
- write_data_out changes only in IDLE on a pop. It is stable from one cycle before the toggle until HOLD exits.
- Latency: a pixel accepted into an empty FIFO at edge N appears on write_data_out after edge N+1. For non-frame-start pixels, the toggle flips after edge N+2.
- Throughput with a 1-cycle echo: one pixel per 4+HOLD_CYCLES cycles.
- Simultaneous push and pop are allowed when not full; the level is unchanged.

Optional Feature:
- Macro: MANDEL_FB_WRITER_AUTO_PTR_RESET_EN
- Defined:
  - A pixel counter (width clog2(FRAME_PIXELS)) increments on each HOLD exit.
  - On reaching FRAME_PIXELS, it clears and forces a PTR_RST before the next nibble, even without pixel_frame_start_in.
  - A popped frame_start also clears the counter, and only one PTR_RST is performed.
- Undefined: the pointer is reset only by pixel_frame_start_in; the counter logic is absent.

Test Plan:
1. After reset, push 0xA with frame_start=0 and echo wrote_data_in one cycle after the toggle -> write_data_out=0xA after edge 1; toggle 0->1 after edge 2; FSM back to IDLE after 4+HOLD_CYCLES=8 cycles; busy_out then low.
2. Push 0x3 with frame_start=1 -> reset_write_ptr_out high for exactly 8 cycles; the toggle flips on the cycle after it falls; write_data_out=0x3 throughout.
3. Stall the echo and push 0x1..0x6 back-to-back -> one pixel popped, 4 stored; pixel_ready_out low with fifo_level_out=4. Release the echo -> nibbles 1..6 emitted in order, one toggle each, 6 toggles total.
4. Hold wrote_data_in at its old value for 20 cycles -> FSM stays in WAIT_ECHO; write_data_out and the toggle are unchanged; no second toggle occurs.
5. Assert rst for one cycle during HOLD with 3 entries queued -> next cycle all outputs are 0 and fifo_level_out=0; pixel_ready_out returns to 1 one cycle later.
6. With MANDEL_FB_WRITER_AUTO_PTR_RESET_EN defined and FRAME_PIXELS=4, push 5 pixels with frame_start=0 -> reset_write_ptr_out pulses for 8 cycles before the 5th toggle only.
